// File: rtl/ext_host_arbiter_if.sv
// Host-side request bundle and external target port of ext_host_arbiter.
// master = arbiter view, slave = host adapters plus target view.
interface ext_host_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
);
  logic [NUM_CH-1:0]        m_req;
  logic [NUM_CH-1:0]        m_wen;
  logic [NUM_CH*ADDR_W-1:0] m_addr;
  logic [NUM_CH*DATA_W-1:0] m_wdata;
  logic [NUM_CH*LEN_W-1:0]  m_blen;
  logic [NUM_CH-1:0]        m_beat_ack;
  logic [NUM_CH-1:0]        m_done;
  logic [NUM_CH-1:0]        m_err;
  logic [DATA_W-1:0]        m_rdata;
  logic                     ext_sel;
  logic                     ext_wen;
  logic                     ext_ren;
  logic [ADDR_W-1:0]        ext_addr;
  logic [DATA_W-1:0]        ext_wdata;
  logic [DATA_W-1:0]        ext_rdata;
  logic                     ext_ready;
  logic                     busy;

  modport master (
    input  m_req, m_wen, m_addr, m_wdata, m_blen, ext_rdata, ext_ready,
    output m_beat_ack, m_done, m_err, m_rdata,
    output ext_sel, ext_wen, ext_ren, ext_addr, ext_wdata, busy
  );

  modport slave (
    output m_req, m_wen, m_addr, m_wdata, m_blen, ext_rdata, ext_ready,
    input  m_beat_ack, m_done, m_err, m_rdata,
    input  ext_sel, ext_wen, ext_ren, ext_addr, ext_wdata, busy
  );
endinterface

// File: rtl/ext_host_arbiter.sv
// Multi-channel burst arbiter onto the single external target port, with per-beat ready timeout.
// Define EXT_ARB_FIXED_PRIO_EN for fixed priority (lowest channel wins); default is round-robin.
module ext_host_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic              clk,
  input logic              rst,
  ext_host_arbiter_if.master bus
);

  localparam int unsigned      PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_gnt;
  logic              r_wen;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_last;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_sel;
  logic              r_ext_wen;
  logic              r_ext_ren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [NUM_CH-1:0] r_beat_ack;
  logic [NUM_CH-1:0] r_done;
  logic [NUM_CH-1:0] r_err;

  logic [ADDR_W-1:0] w_addr  [NUM_CH];
  logic [DATA_W-1:0] w_wdata [NUM_CH];
  logic [LEN_W-1:0]  w_blen  [NUM_CH];
  logic              w_gnt_vld;
  logic [PTR_W-1:0]  w_gnt;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.m_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = bus.m_wdata[gi*DATA_W +: DATA_W];
    assign w_blen[gi]  = bus.m_blen[gi*LEN_W +: LEN_W];
  end

`ifdef EXT_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_vld && bus.m_req[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] r_rr_ptr;

  // Two passes: channels at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_vld && bus.m_req[i] && (PTR_W'(i) >= r_rr_ptr)) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_vld && bus.m_req[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PTR_W'(i);
      end
    end
  end

  // Pointer moves during the closing GAP, before IDLE arbitrates again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_GAP && r_last) begin
      r_rr_ptr <= (r_gnt == PTR_W'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_wen      <= 1'b0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_tmr      <= '0;
      r_sel      <= 1'b0;
      r_ext_wen  <= 1'b0;
      r_ext_ren  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_beat_ack <= '0;
      r_done     <= '0;
      r_err      <= '0;
    end else begin
      r_beat_ack <= '0;
      r_done     <= '0;
      r_err      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt     <= w_gnt;
            r_wen     <= bus.m_wen[w_gnt];
            r_addr    <= w_addr[w_gnt];
            r_cnt     <= w_blen[w_gnt];
            r_wdata   <= w_wdata[w_gnt];
            r_sel     <= 1'b1;
            r_ext_wen <= bus.m_wen[w_gnt];
            r_ext_ren <= ~bus.m_wen[w_gnt];
            r_tmr     <= '0;
            r_last    <= 1'b0;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.ext_ready) begin
            r_sel             <= 1'b0;
            r_ext_wen         <= 1'b0;
            r_ext_ren         <= 1'b0;
            r_beat_ack[r_gnt] <= 1'b1;
            if (!r_wen) r_rdata <= bus.ext_rdata;
            if (r_cnt == '0) begin
              r_done[r_gnt] <= 1'b1;
              r_last        <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
            r_state <= S_GAP;
          end else if (TIMEOUT > 0 && r_tmr == TMR_LAST) begin
            r_sel         <= 1'b0;
            r_ext_wen     <= 1'b0;
            r_ext_ren     <= 1'b0;
            r_done[r_gnt] <= 1'b1;
            r_err[r_gnt]  <= 1'b1;
            r_last        <= 1'b1;
            r_state       <= S_GAP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_GAP: begin
          if (r_last) begin
            r_state <= S_IDLE;
          end else begin
            r_addr    <= r_addr + ADDR_W'(ADDR_STRIDE);
            r_wdata   <= w_wdata[r_gnt];
            r_sel     <= 1'b1;
            r_ext_wen <= r_wen;
            r_ext_ren <= ~r_wen;
            r_tmr     <= '0;
            r_state   <= S_ACCESS;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ext_sel    = r_sel;
  assign bus.ext_wen    = r_ext_wen;
  assign bus.ext_ren    = r_ext_ren;
  assign bus.ext_addr   = r_addr;
  assign bus.ext_wdata  = r_wdata;
  assign bus.m_rdata    = r_rdata;
  assign bus.m_beat_ack = r_beat_ack;
  assign bus.m_done     = r_done;
  assign bus.m_err      = r_err;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ext_host_arbiter.sv
// Directed bench for ext_host_arbiter: single write, read burst, arbitration order,
// timeout, reset mid-burst and address wrap. Build with EXT_ARB_FIXED_PRIO_EN to check fixed priority.
module tb_ext_host_arbiter;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_host_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  ext_host_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STRIDE(4), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Target model: ready after rdy_dly extra sel cycles, read data = addr ^ 0xA5A5.
  int acc_cnt;
  int rdy_dly;
  bit rdy_never;
  always @(posedge clk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else     acc_cnt <= bus.ext_sel ? acc_cnt + 1 : 0;
  end
  assign bus.ext_ready = bus.ext_sel && !rdy_never && (acc_cnt >= rdy_dly);
  assign bus.ext_rdata = bus.ext_addr ^ 32'h0000_A5A5;

  // Event log sampled on the falling edge.
  logic [31:0] q_baddr[$], q_bwen[$], q_bwd[$];
  logic [31:0] q_ach[$], q_ard[$], q_adone[$];
  logic [31:0] q_dch[$], q_derr[$];
  int n_rise, n_selcyc;
  bit prev_sel;
  always @(negedge clk) begin
    if (bus.ext_sel && !prev_sel) n_rise++;
    if (bus.ext_sel) n_selcyc++;
    prev_sel = bus.ext_sel;
    if (bus.ext_sel && bus.ext_ready) begin
      q_baddr.push_back(bus.ext_addr);
      q_bwen.push_back(32'(bus.ext_wen));
      q_bwd.push_back(bus.ext_wdata);
    end
    for (int c = 0; c < NCH; c++) begin
      if (bus.m_beat_ack[c]) begin
        q_ach.push_back(32'(c));
        q_ard.push_back(bus.m_rdata);
        q_adone.push_back(32'(bus.m_done[c]));
      end
      if (bus.m_done[c]) begin
        q_dch.push_back(32'(c));
        q_derr.push_back(32'(bus.m_err[c]));
      end
    end
  end

  int n_chk, n_pass;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  int b_b, b_a, b_d, b_rise, b_cyc;
  task automatic mark();
    b_b = q_baddr.size(); b_a = q_ach.size(); b_d = q_dch.size();
    b_rise = n_rise; b_cyc = n_selcyc;
  endtask

  task automatic setup(input int ch, input logic wen, input logic [31:0] addr,
                       input logic [3:0] blen, input logic [31:0] wd);
    bus.m_wen[ch]            = wen;
    bus.m_addr[ch*AW +: AW]  = addr;
    bus.m_blen[ch*LW +: LW]  = blen;
    bus.m_wdata[ch*DW +: DW] = wd;
  endtask

  bit requeue0;
  task automatic run(input int max_cyc);
    int n = 0;
    while ((bus.m_req != '0 || bus.busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
      for (int c = 0; c < NCH; c++) begin
        if (bus.m_done[c]) begin
          if (c == 0 && requeue0) requeue0 = 1'b0;
          else bus.m_req[c] = 1'b0;
        end
      end
    end
    check("run_bound", 32'(n < max_cyc), 32'd1);
  endtask

  logic [31:0] exp_rd[4];
  logic [31:0] exp_ord[4];

  initial begin
    rst = 1'b1;
    bus.m_req = '0; bus.m_wen = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_blen = '0;
    rdy_dly = 0; rdy_never = 1'b0; requeue0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {29'b0, bus.ext_sel, bus.ext_wen, bus.ext_ren}, 32'd0);
    check("rst_addr", bus.ext_addr, 32'd0);
    check("rst_wdata", bus.ext_wdata, 32'd0);
    check("rst_rdata", bus.m_rdata, 32'd0);
    check("rst_pulses", {20'b0, bus.m_beat_ack, bus.m_done, bus.m_err}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, ready in the third sel cycle.
    mark(); rdy_dly = 2;
    setup(0, 1'b1, 32'h1014, 4'd0, 32'h0004_0004);
    bus.m_req[0] = 1'b1;
    @(negedge clk);
    check("wr_latency_sel", 32'(bus.ext_sel), 32'd1);
    run(50);
    check("wr_sel_rises", 32'(n_rise - b_rise), 32'd1);
    check("wr_sel_cycles", 32'(n_selcyc - b_cyc), 32'd3);
    check("wr_beat_addr", qget(q_baddr, b_b), 32'h1014);
    check("wr_beat_wen", qget(q_bwen, b_b), 32'd1);
    check("wr_beat_wdata", qget(q_bwd, b_b), 32'h0004_0004);
    check("wr_acks", 32'(q_ach.size() - b_a), 32'd1);
    check("wr_ack_ch", qget(q_ach, b_a), 32'd0);
    check("wr_ack_with_done", qget(q_adone, b_a), 32'd1);
    check("wr_busy_end", 32'(bus.busy), 32'd0);

    // Read burst of four beats on ch1.
    mark(); rdy_dly = 1;
    setup(1, 1'b0, 32'h1008, 4'd3, 32'h0);
    bus.m_req[1] = 1'b1;
    run(100);
    exp_rd = '{32'h1008, 32'h100C, 32'h1010, 32'h1014};
    check("rd_beats", 32'(q_baddr.size() - b_b), 32'd4);
    check("rd_sel_rises", 32'(n_rise - b_rise), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_addr%0d", i), qget(q_baddr, b_b + i), exp_rd[i]);
      check($sformatf("rd_data%0d", i), qget(q_ard, b_a + i), exp_rd[i] ^ 32'h0000_A5A5);
      check($sformatf("rd_done%0d", i), qget(q_adone, b_a + i), (i == 3) ? 32'd1 : 32'd0);
    end
    check("rd_ack_ch", qget(q_ach, b_a), 32'd1);
    check("rd_done_count", 32'(q_dch.size() - b_d), 32'd1);

    // Arbitration: ch0, ch2, ch3 together, ch0 requeued after its first grant.
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    mark(); rdy_dly = 0;
    setup(0, 1'b1, 32'h1000, 4'd0, 32'h11);
    setup(2, 1'b1, 32'h1008, 4'd0, 32'h22);
    setup(3, 1'b1, 32'h100C, 4'd0, 32'h33);
    requeue0 = 1'b1;
    bus.m_req = 4'b1101;
    run(100);
`ifdef EXT_ARB_FIXED_PRIO_EN
    exp_ord = '{32'd0, 32'd0, 32'd2, 32'd3};
`else
    exp_ord = '{32'd0, 32'd2, 32'd3, 32'd0};
`endif
    check("arb_grants", 32'(q_dch.size() - b_d), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_order%0d", i), qget(q_dch, b_d + i), exp_ord[i]);

    // Timeout: ready never comes.
    mark(); rdy_never = 1'b1;
    setup(0, 1'b0, 32'h1018, 4'd0, 32'h0);
    bus.m_req[0] = 1'b1;
    run(100);
    check("to_sel_cycles", 32'(n_selcyc - b_cyc), 32'd16);
    check("to_done_ch", qget(q_dch, b_d), 32'd0);
    check("to_err", qget(q_derr, b_d), 32'd1);
    check("to_no_ack", 32'(q_ach.size() - b_a), 32'd0);
    check("to_busy_end", 32'(bus.busy), 32'd0);

    // Ready arrives on the 16th cycle: completes without error.
    mark(); rdy_never = 1'b0; rdy_dly = 15;
    bus.m_req[0] = 1'b1;
    run(100);
    check("to16_sel_cycles", 32'(n_selcyc - b_cyc), 32'd16);
    check("to16_acks", 32'(q_ach.size() - b_a), 32'd1);
    check("to16_err", qget(q_derr, b_d), 32'd0);

    // Reset during beat 2 of 4, then a fresh ch0 request.
    mark(); rdy_dly = 2;
    setup(0, 1'b0, 32'h1000, 4'd3, 32'h0);
    bus.m_req[0] = 1'b1;
    begin
      int n = 0;
      while (!(q_ach.size() > b_a && bus.ext_sel) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rm_wait_beat2", 32'(n < 100), 32'd1);
    end
    rst = 1'b1;
    #1;
    check("rm_strobes", {29'b0, bus.ext_sel, bus.ext_wen, bus.ext_ren}, 32'd0);
    check("rm_addr", bus.ext_addr, 32'd0);
    check("rm_rdata", bus.m_rdata, 32'd0);
    check("rm_busy", 32'(bus.busy), 32'd0);
    check("rm_no_done", 32'(q_dch.size() - b_d), 32'd0);
    @(negedge clk);
    setup(0, 1'b0, 32'h1000, 4'd0, 32'h0);
    rst = 1'b0;
    mark();
    run(50);
    check("rm_restart_addr", qget(q_baddr, b_b), 32'h1000);
    check("rm_restart_done", 32'(q_dch.size() - b_d), 32'd1);

    // Address wrap at the top of the space.
    mark(); rdy_dly = 0;
    setup(1, 1'b0, 32'hFFFF_FFFC, 4'd1, 32'h0);
    bus.m_req[1] = 1'b1;
    run(50);
    check("wrap_addr0", qget(q_baddr, b_b), 32'hFFFF_FFFC);
    check("wrap_addr1", qget(q_baddr, b_b + 1), 32'h0000_0000);
    check("wrap_rdata1", qget(q_ard, b_a + 1), 32'h0000_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
